// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I encoding definitions.
// Contents: the instruction format enum, the 5-bit major-opcode groups used by the
// immediate generator, and the encode_word() packing function.
// Optional feature: IMMENC_RANGE_CHECK_EN enables the immediate range/alignment check.
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // Major opcode groups (opcode[6:2]); opcode[1:0] is always 2'b11 for RV32I.
   localparam logic [4:0] OPG_LOAD   = 5'b00000;
   localparam logic [4:0] OPG_OP_IMM = 5'b00100;
   localparam logic [4:0] OPG_AUIPC  = 5'b00101;
   localparam logic [4:0] OPG_STORE  = 5'b01000;
   localparam logic [4:0] OPG_OP     = 5'b01100;
   localparam logic [4:0] OPG_LUI    = 5'b01101;
   localparam logic [4:0] OPG_BRANCH = 5'b11000;
   localparam logic [4:0] OPG_JALR   = 5'b11001;
   localparam logic [4:0] OPG_JAL    = 5'b11011;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } enc_t;

   // Pack decoded fields into a 32-bit word; illegal formats yield a zero word with err set.
   function automatic enc_t encode_word(
      input logic [2:0]  fmt,
      input logic [6:0]  opcode,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  funct3,
      input logic [6:0]  funct7,
      input logic [31:0] imm
   );
      enc_t r;
`ifdef IMMENC_RANGE_CHECK_EN
      logic signed [31:0] s;
      s = $signed(imm);
`endif
      r.instr = 32'h0;
      r.err   = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: r.instr = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            r.instr = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMMENC_RANGE_CHECK_EN
            r.err = (s < -32'sd2048) || (s > 32'sd2047);
`endif
         end
         FMT_S: begin
            r.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef IMMENC_RANGE_CHECK_EN
            r.err = (s < -32'sd2048) || (s > 32'sd2047);
`endif
         end
         FMT_B: begin
            r.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef IMMENC_RANGE_CHECK_EN
            r.err = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
`endif
         end
         FMT_U: begin
            r.instr = {imm[31:12], rd, opcode};
`ifdef IMMENC_RANGE_CHECK_EN
            r.err = (imm[11:0] != 12'h000);
`endif
         end
         FMT_J: begin
            r.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef IMMENC_RANGE_CHECK_EN
            r.err = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
`endif
         end
         default: begin
            r.instr = 32'h0;
            r.err   = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// instr_skid_buf: 2-entry (main + skid) valid/ready buffer, FIFO order.
// in_ready_o is registered and equals "skid entry empty"; a consumed main entry is
// refilled from skid in the same cycle.
module instr_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         main_valid_reg, main_valid_next;
   logic         skid_valid_reg, skid_valid_next;
   logic         ready_reg;
   logic [W-1:0] main_data_reg, main_data_next;
   logic [W-1:0] skid_data_reg, skid_data_next;
   logic         accept;
   logic         consume;

   assign accept      = in_valid_i & ready_reg;
   assign consume     = main_valid_reg & out_ready_i;
   assign in_ready_o  = ready_reg;
   assign out_valid_o = main_valid_reg;
   assign out_data_o  = main_data_reg;

   // Next-state of the two entries: drain skid into main on consume, park new words in skid when main is stuck.
   always_comb begin
      main_valid_next = main_valid_reg;
      skid_valid_next = skid_valid_reg;
      main_data_next  = main_data_reg;
      skid_data_next  = skid_data_reg;
      if (consume) begin
         if (skid_valid_reg) begin
            // skid full implies in_ready was low, so no accept can coincide here
            main_data_next  = skid_data_reg;
            skid_valid_next = 1'b0;
         end else if (accept) begin
            main_data_next  = in_data_i;
         end else begin
            main_valid_next = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_reg) begin
            skid_data_next  = in_data_i;
            skid_valid_next = 1'b1;
         end else begin
            main_data_next  = in_data_i;
            main_valid_next = 1'b1;
         end
      end
   end

   // Entry registers; ready is registered from the next skid occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         ready_reg      <= 1'b1;
         main_data_reg  <= '0;
         skid_data_reg  <= '0;
      end else begin
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         ready_reg      <= ~skid_valid_next;
         main_data_reg  <= main_data_next;
         skid_data_reg  <= skid_data_next;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction word packer with word-address tagging.
// Encodes at acceptance, tags with a wrapping address counter, and buffers
// {instr, addr, err} in a 2-entry skid buffer.
// Optional feature: IMMENC_RANGE_CHECK_EN (immediate range check, see riscv_pkg).
module instr_encoder
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        fmt_i,
   input  logic [6:0]        opcode_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [31:0]       imm_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              err_o,
   output logic              err_sticky_o
);

   localparam int W = 32 + ADDR_W + 1;

   enc_t              enc;
   logic              accept;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic [ADDR_W-1:0] word_addr;
   logic              sticky_reg, sticky_next;
   logic [W-1:0]      buf_in;
   logic [W-1:0]      buf_out;

   assign enc    = encode_word(fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
   assign accept = in_valid_i & in_ready_o;
   assign buf_in = {enc.instr, word_addr, enc.err};

   // Address and sticky-error next state; a clear coinciding with an accept gives that word addr 0.
   always_comb begin
      word_addr   = clr_i ? '0 : cnt_reg;
      cnt_next    = cnt_reg;
      sticky_next = clr_i ? 1'b0 : sticky_reg;
      if (accept) begin
         cnt_next    = word_addr + ADDR_W'(1);
         sticky_next = sticky_next | enc.err;
      end else if (clr_i) begin
         cnt_next = '0;
      end
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_reg    <= '0;
         sticky_reg <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         sticky_reg <= sticky_next;
      end
   end

   instr_skid_buf #(
      .W (W)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (buf_in),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (buf_out)
   );

   assign instr_o      = buf_out[W-1 -: 32];
   assign addr_o       = buf_out[ADDR_W:1];
   assign err_o        = buf_out[0];
   assign err_sticky_o = sticky_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder (ADDR_W=10 and a 2-bit wrap instance).
module tb_instr_encoder;

`ifdef IMMENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   logic        clk, rst, clr, in_valid, out_ready;
   logic [2:0]  fmt, f3;
   logic [6:0]  op, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        in_ready, out_valid, err, sticky;
   logic [31:0] instr;
   logic [9:0]  addr;
   logic        w_in_ready, w_out_valid, w_err, w_sticky;
   logic [31:0] w_instr;
   logic [1:0]  w_addr;

   int checks = 0;
   int errors = 0;

   instr_encoder #(.ADDR_W(10)) u_dut (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .fmt_i(fmt), .opcode_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3),
      .funct7_i(f7), .imm_i(imm), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .instr_o(instr), .addr_o(addr), .err_o(err), .err_sticky_o(sticky)
   );

   instr_encoder #(.ADDR_W(2)) u_wrap (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(w_in_ready),
      .fmt_i(fmt), .opcode_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3),
      .funct7_i(f7), .imm_i(imm), .out_valid_o(w_out_valid), .out_ready_i(out_ready),
      .instr_o(w_instr), .addr_o(w_addr), .err_o(w_err), .err_sticky_o(w_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   // One word through an empty buffer with out_ready high; result checked one cycle later.
   task automatic send(input string tag, input logic [2:0] f, input logic [6:0] o,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] t3, input logic [6:0] t7, input logic [31:0] im,
                       input logic c, input logic [31:0] ei, input int ea,
                       input logic ee, input logic es);
      logic [9:0] ea10;
      ea10 = 10'(ea);
      @(negedge clk);
      fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; f3 = t3; f7 = t7; imm = im;
      clr = c; in_valid = 1'b1;
      check({tag, "_rdy"}, 64'(in_ready), 64'(1));
      @(posedge clk);
      #1 in_valid = 1'b0; clr = 1'b0;
      @(negedge clk);
      check({tag, "_vld"},   64'(out_valid), 64'(1));
      check({tag, "_instr"}, 64'(instr), 64'(ei));
      check({tag, "_addr"},  64'(addr), 64'(ea10));
      check({tag, "_waddr"}, 64'(w_addr), 64'(ea10[1:0]));
      check({tag, "_err"},   64'(err), 64'(ee));
      check({tag, "_stky"},  64'(sticky), 64'(es));
      $display("txn %s instr=%h addr=%0d err=%0d sticky=%0d", tag, instr, addr, err, sticky);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   initial begin
      int acc;
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      fmt = '0; op = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_vld",   64'(out_valid), 64'(0));
      check("rst_rdy",   64'(in_ready), 64'(1));
      check("rst_instr", 64'(instr), 64'(0));
      check("rst_addr",  64'(addr), 64'(0));
      check("rst_err",   64'(err), 64'(0));
      check("rst_stky",  64'(sticky), 64'(0));

      send("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         1'b0, 32'h00500093, 0, 1'b0, 1'b0);
      send("jal",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      1'b0, 32'h001000EF, 1, 1'b0, 1'b0);
      send("sw",   3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         1'b0, 32'h0020A423, 2, 1'b0, 1'b0);
      send("beq",  3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC,  1'b0, 32'hFE000EE3, 3, 1'b0, 1'b0);
      send("lui",  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,  1'b0, 32'h123452B7, 4, 1'b0, 1'b0);
      send("bmax", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,      1'b0, 32'h7E000FE3, 5, 1'b0, 1'b0);
      send("add",  3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFF,  1'b0, 32'h002081B3, 6, 1'b0, 1'b0);
      send("sub",  3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         1'b0, 32'h402081B3, 7, 1'b0, 1'b0);
      send("imin", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800,  1'b0, 32'h80000013, 8, 1'b0, 1'b0);
      send("iovf", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      1'b0, 32'h80000013, 9, RC,   RC);
      send("ill7", 3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0,         1'b0, 32'h00000000, 10, 1'b1, 1'b1);

      // Clear alone: sticky drops, counter restarts.
      clr_pulse();
      @(negedge clk);
      check("clr_stky", 64'(sticky), 64'(0));
      send("pclr", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,         1'b0, 32'h00100093, 0, 1'b0, 1'b0);
      // Clear coinciding with an erroring accept.
      send("cacc", 3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,         1'b1, 32'h00000000, 0, 1'b1, 1'b1);
      send("post", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2,         1'b0, 32'h00200093, 1, 1'b0, 1'b1);

      // Backpressure: offer 5 words with out_ready low.
      clr_pulse();
      @(negedge clk);
      out_ready = 1'b0;
      acc = 0;
      fmt = 3'd1; op = 7'h13; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; f3 = 3'd0; f7 = 7'h00;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         in_valid = 1'b1;
         imm = 32'(10 + acc);
         if (in_ready) acc++;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_acc",   64'(acc), 64'(2));
      check("bp_rdy0",  64'(in_ready), 64'(0));
      check("bp_vld",   64'(out_valid), 64'(1));
      check("bp_w0",    64'(instr), 64'(32'h00A00013));
      @(negedge clk);
      check("bp_hold",  64'(instr), 64'(32'h00A00013));
      check("bp_hadr",  64'(addr), 64'(0));
      out_ready = 1'b1;
      check("bp_rdyrel", 64'(in_ready), 64'(0));
      $display("txn bp0 instr=%h addr=%0d", instr, addr);
      @(negedge clk);
      check("bp_rdy1",  64'(in_ready), 64'(1));
      check("bp_v1",    64'(out_valid), 64'(1));
      check("bp_w1",    64'(instr), 64'(32'h00B00013));
      check("bp_a1",    64'(addr), 64'(1));
      $display("txn bp1 instr=%h addr=%0d", instr, addr);
      @(negedge clk);
      check("bp_empty", 64'(out_valid), 64'(0));

      // Address wrap on the 2-bit instance.
      clr_pulse();
      for (int k = 0; k < 5; k++) begin
         send("wrap", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'(k), 1'b0,
              32'h00000013 | (32'(k) << 20), k, 1'b0, 1'b0);
      end

      // Reset mid-stream discards buffered words.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      imm = 32'd7;
      @(posedge clk);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("mr_pre", 64'(out_valid), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("mr_vld", 64'(out_valid), 64'(0));
      check("mr_rdy", 64'(in_ready), 64'(1));
      check("mr_addr", 64'(addr), 64'(0));
      @(negedge clk);
      check("mr_vld2", 64'(out_valid), 64'(0));
      send("mrnew", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b0, 32'h00500093, 0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
